wb_rr_arbiter: RTL

//  Two-master round-robin arbiter and bus watchdog for the 16-bit SoC wishbone bus.

---
 rtl/wb_rr_arbiter_pkg.sv | 37 +++
 rtl/wb_rr_arbiter_watchdog.sv | 46 ++++
 rtl/wb_rr_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the two-master wishbone round-robin arbiter.
// Bus widths normally come from the SoC-wide config defines; the fallbacks
// below only apply when this slice is compiled without that shared file.
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef WB_DATA_W
`define WB_DATA_W 16
`endif
`ifndef WB_SEL_BITS
`define WB_SEL_BITS 2
`endif

package wb_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // Round-robin pointer encoding: which master wins the next contention.
    localparam logic RR_M0 = 1'b0;
    localparam logic RR_M1 = 1'b1;

    // One-hot owner vector for a given arbiter state (2'b00 when idle).
    function automatic logic [1:0] grant_of(arb_state_t st);
        logic [1:0] g;
        case (st)
            ST_OWN0: g = 2'b01;
            ST_OWN1: g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_watchdog.sv
// Bus watchdog: counts stalled strobe cycles of the current owner and
// raises a one-cycle fire in the TIMEOUT_CYC-th stalled cycle.
module wb_watchdog #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,   // a master currently owns the bus
    input  logic i_clear,    // owner changes at the coming edge
    input  logic i_stb,      // owner strobe (before masking)
    input  logic i_ack,      // slave ack
    input  logic i_err,      // slave err
    output logic o_fire
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fire_s;

    // Fire compare and next counter value; any response, idle strobe,
    // owner change or the fire itself restarts the count.
    always_comb begin
        fire_s = i_active & (cnt_q == LAST_CNT) & i_stb & ~i_ack & ~i_err;
        cnt_d  = cnt_q;
        if (!i_active || i_clear || !i_stb || i_ack || i_err || fire_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_fire = fire_s;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin wishbone arbiter. Grant is held for a whole cyc,
// the round-robin pointer flips on every release, and the watchdog
// terminates hung strobes with err towards the owner.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      m0_wb_cyc,
    input  logic                      m0_wb_stb,
    input  logic                      m0_wb_we,
    input  logic [`WB_ADDR_W-1:0]     m0_wb_adr,
    input  logic [`WB_SEL_BITS-1:0]   m0_wb_sel,
    input  logic [`WB_DATA_W-1:0]     m0_wb_i_dat,
    output logic [`WB_DATA_W-1:0]     m0_wb_o_dat,
    output logic                      m0_wb_ack,
    output logic                      m0_wb_err,
    input  logic                      m1_wb_cyc,
    input  logic                      m1_wb_stb,
    input  logic                      m1_wb_we,
    input  logic [`WB_ADDR_W-1:0]     m1_wb_adr,
    input  logic [`WB_SEL_BITS-1:0]   m1_wb_sel,
    input  logic [`WB_DATA_W-1:0]     m1_wb_i_dat,
    output logic [`WB_DATA_W-1:0]     m1_wb_o_dat,
    output logic                      m1_wb_ack,
    output logic                      m1_wb_err,
    output logic                      s_wb_cyc,
    output logic                      s_wb_stb,
    output logic                      s_wb_we,
    output logic [`WB_ADDR_W-1:0]     s_wb_adr,
    output logic [`WB_SEL_BITS-1:0]   s_wb_sel,
    output logic [`WB_DATA_W-1:0]     s_wb_o_dat,
    input  logic [`WB_DATA_W-1:0]     s_wb_i_dat,
    input  logic                      s_wb_ack,
    input  logic                      s_wb_err,
    output logic [1:0]                o_grant,
    output logic                      o_timeout
);

    arb_state_t state_q, state_d;
    logic       rr_q, rr_d;
    logic       own_active_s;
    logic       own_stb_s;
    logic       owner_change_s;
    logic       wdt_fire_s;

    // Next owner: pointer breaks ties in IDLE; on release hand straight
    // over to the other master if it is already requesting.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_wb_cyc && m1_wb_cyc) begin
                    state_d = (rr_q == RR_M1) ? ST_OWN1 : ST_OWN0;
                end else if (m0_wb_cyc) begin
                    state_d = ST_OWN0;
                end else if (m1_wb_cyc) begin
                    state_d = ST_OWN1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!m0_wb_cyc) begin
                    rr_d    = RR_M1;
                    state_d = m1_wb_cyc ? ST_OWN1 : ST_IDLE;
                end else begin
                    state_d = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (!m1_wb_cyc) begin
                    rr_d    = RR_M0;
                    state_d = m0_wb_cyc ? ST_OWN0 : ST_IDLE;
                end else begin
                    state_d = ST_OWN1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rr_d    = RR_M0;
            end
        endcase
    end

    // Owner state and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= RR_M0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Owner strobe seen by the watchdog (kept apart from the output mux so
    // the masked strobe never loops back into the fire compare).
    always_comb begin
        own_active_s   = 1'b0;
        own_stb_s      = 1'b0;
        owner_change_s = (state_d != state_q);
        case (state_q)
            ST_OWN0: begin
                own_active_s = 1'b1;
                own_stb_s    = m0_wb_stb;
            end
            ST_OWN1: begin
                own_active_s = 1'b1;
                own_stb_s    = m1_wb_stb;
            end
            default: begin
                own_active_s = 1'b0;
                own_stb_s    = 1'b0;
            end
        endcase
    end

    wb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_wdt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_active (own_active_s),
        .i_clear  (owner_change_s),
        .i_stb    (own_stb_s),
        .i_ack    (s_wb_ack),
        .i_err    (s_wb_err),
        .o_fire   (wdt_fire_s)
    );

    // Request path to the slave and response path back to the owner only.
    always_comb begin
        s_wb_cyc    = 1'b0;
        s_wb_stb    = 1'b0;
        s_wb_we     = 1'b0;
        s_wb_adr    = '0;
        s_wb_sel    = '0;
        s_wb_o_dat  = '0;
        m0_wb_o_dat = '0;
        m0_wb_ack   = 1'b0;
        m0_wb_err   = 1'b0;
        m1_wb_o_dat = '0;
        m1_wb_ack   = 1'b0;
        m1_wb_err   = 1'b0;
        o_timeout   = 1'b0;
        case (state_q)
            ST_OWN0: begin
                s_wb_cyc    = m0_wb_cyc;
                s_wb_stb    = m0_wb_stb & ~wdt_fire_s;
                s_wb_we     = m0_wb_we;
                s_wb_adr    = m0_wb_adr;
                s_wb_sel    = m0_wb_sel;
                s_wb_o_dat  = m0_wb_i_dat;
                m0_wb_o_dat = s_wb_i_dat;
                m0_wb_ack   = s_wb_ack;
                m0_wb_err   = s_wb_err | wdt_fire_s;
                o_timeout   = wdt_fire_s;
            end
            ST_OWN1: begin
                s_wb_cyc    = m1_wb_cyc;
                s_wb_stb    = m1_wb_stb & ~wdt_fire_s;
                s_wb_we     = m1_wb_we;
                s_wb_adr    = m1_wb_adr;
                s_wb_sel    = m1_wb_sel;
                s_wb_o_dat  = m1_wb_i_dat;
                m1_wb_o_dat = s_wb_i_dat;
                m1_wb_ack   = s_wb_ack;
                m1_wb_err   = s_wb_err | wdt_fire_s;
                o_timeout   = wdt_fire_s;
            end
            default: begin
                o_timeout = 1'b0;
            end
        endcase
    end

    assign o_grant = grant_of(state_q);

endmodule
